dwrr_req_queues: RTL and testbench
==================================

Name: dwrr_req_queues

Overview:
- Requestor-side front end for the DWRR arbiter: one packet FIFO per requestor.
- Each FIFO drives its `reqs` bit.
- Consumes the arbiter's `gnt` vector: pops the granted head entry and presents it on a single registered output stream tagged with the queue id.
- Sits between the packet producers and the DWRR arbiter, closing the req/gnt loop.

Parameters:
- NUM_REQS, 4, number of requestor queues; matches the arbiter's NUM_REQS.
- DWID, 8, data word width per queue entry.
- DEPTH, 4, entries per queue; must be a power of 2 and at least 2.
- CNTWID, $clog2(NUM_REQS), width of the out_id field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  NUM_REQS  per-queue enqueue strobe.
- push_data  input  NUM_REQS*DWID  enqueue data; queue i uses bits [(i+1)*DWID-1:i*DWID].
- full  output  NUM_REQS  queue i holds DEPTH entries.
- blk  input  1  suppress all requests this cycle.
- reqs  output  NUM_REQS  to arbiter; request from queue i.
- gnt  input  NUM_REQS  from arbiter; grant, expected one-hot or zero.
- out_valid  output  1  out_data/out_id valid this cycle.
- out_data  output  DWID  popped entry.
- out_id  output  CNTWID  index of the queue that was popped.
- err  output  1  sticky protocol-error flag; see Optional Feature.

Behaviour:
- Reset (async assert, synchronous release):
  - all counts, read pointers and write pointers = 0.
  - out_valid = 0, out_data = 0, out_id = 0, err = 0.
  - Reset mid-operation discards every queued entry and any pending output.
- Per-queue state:
  - wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrap modulo DEPTH.
  - count, $clog2(DEPTH+1) bits, range 0..DEPTH.
- Combinational outputs:
  - full[i] = (count_i == DEPTH).
  - reqs[i] = (count_i != 0) & ~blk. reqs is combinational from registered state and blk only; there is no path from gnt to reqs.
- Push:
  - Accepted when push[i] & ~full[i] at the clock edge.
  - Writes mem[wr_ptr], wr_ptr+1, count+1.
  - A push while full is dropped silently; state is unchanged.
  - full is evaluated on the pre-edge count. A same-cycle pop does not make room for a push to a full queue.
- Pop:
  - pop_i = gnt[i] & (count_i != 0) & lowest set bit of gnt.
  - On pop: rd_ptr+1, count-1.
  - Next cycle: out_valid = 1, out_data = mem[rd_ptr] (pre-edge value), out_id = i.
  - Latency gnt -> out_valid is exactly 1 cycle.
  - out_valid is high for exactly one cycle per pop; there is no backpressure.
  - Cycles without a pop: out_valid = 0; out_data and out_id hold their last values.
- Simultaneous push and pop on the same queue:
  - count unchanged; both pointers advance.
  - On a 1-entry queue, the popped word is the old head, not the new push.
- Grant to an empty queue: ignored, no pop, out_valid = 0 next cycle.
- Multiple gnt bits set: only the lowest index is served.
- gnt while blk = 1 is still honoured if the queue is non-empty. blk only gates reqs.
- Pointer wrap: after DEPTH pushes and pops, data order is preserved (FIFO order per queue).
- No ordering guarantee across queues; ordering across queues is the arbiter's job.

Optional Feature:
- Macro: DWRR_GNT_CHECK_EN.
- Defined: err sets on the next edge and stays set until rst when any of these occurs:
  - gnt has more than one bit set.
  - gnt[i] is asserted while count_i == 0.
  - gnt[i] is asserted while reqs[i] == 0 (includes during blk).
  - Pop behaviour is unchanged; err is report-only.
- Not defined: err is tied to 0 and no check logic is built.

Test Plan:
- After reset, push 0xA1 then 0xA2 into queue 2 and pulse gnt=4'b0100 on two consecutive cycles -> reqs=4'b0100 before the pops, out_valid pulses with out_data 0xA1 then 0xA2, out_id=2 both cycles; reqs[2]=0 afterwards.
- Push DEPTH=4 entries into queue 0, then a fifth push with data 0xFF -> full[0]=1 and 0xFF is dropped; four grants return only the first four words in order.
- Queue 1 holds 1 entry; push 0x55 and gnt=4'b0010 in the same cycle -> out_data = old head, count_1 stays 1, next grant returns 0x55.
- Queues 0 and 3 non-empty with blk=1 -> reqs=0; with gnt=4'b1001 -> only queue 0 pops (out_id=0); with DWRR_GNT_CHECK_EN defined, err=1 and stays 1 until rst.
- Run 3*DEPTH push/pop pairs on queue 1 with incrementing data -> output sequence is strictly incrementing across pointer wraps.
- Assert rst mid-stream with queues partly full and out_valid=1 -> outputs go to 0 immediately, reqs=0; after release, a gnt produces no out_valid.

Source files
------------

// File: rtl/dwrr_req_queues.sv
// dwrr_req_queues: requestor-side front end for the DWRR arbiter.
// One packet FIFO per requestor drives the matching reqs bit; the arbiter's
// gnt vector pops the granted head. The popped word appears one cycle later
// on a single registered stream tagged with the queue id.
// Optional macro DWRR_GNT_CHECK_EN builds a sticky grant-protocol checker on err;
// without it err is tied low.
module dwrr_req_queues #(
    parameter int NUM_REQS = 4,
    parameter int DWID     = 8,
    parameter int DEPTH    = 4,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      push,
    input  logic [NUM_REQS*DWID-1:0] push_data,
    output logic [NUM_REQS-1:0]      full,
    input  logic                     blk,
    output logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS-1:0]      gnt,
    output logic                     out_valid,
    output logic [DWID-1:0]          out_data,
    output logic [CNTWID-1:0]        out_id,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [NUM_REQS-1:0]      not_empty;
    logic [NUM_REQS-1:0]      push_ok;
    logic [NUM_REQS-1:0]      pop_sel;
    logic [NUM_REQS-1:0]      gnt_low;
    logic [NUM_REQS*DWID-1:0] head_flat;

    logic                     pop_any;
    logic [DWID-1:0]          sel_data;
    logic [CNTWID-1:0]        sel_id;

    // Isolate the lowest set grant bit so a malformed multi-bit grant serves one queue.
    assign gnt_low = gnt & (~gnt + NUM_REQS'(1));

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_queue
        logic [DWID-1:0] mem [DEPTH];
        logic [PW-1:0]   wr_ptr_reg;
        logic [PW-1:0]   rd_ptr_reg;
        logic [CW-1:0]   count_reg;

        assign not_empty[gi] = (count_reg != '0);
        assign full[gi]      = (count_reg == DEPTH_C);
        // Requests depend only on stored state and blk, never on gnt.
        assign reqs[gi]      = not_empty[gi] & ~blk;
        // Full is judged on the pre-edge count; a same-cycle pop does not free a slot.
        assign push_ok[gi]   = push[gi] & ~full[gi];
        assign pop_sel[gi]   = gnt_low[gi] & not_empty[gi];

        assign head_flat[gi*DWID +: DWID] = mem[rd_ptr_reg];

        // Queue storage: written on accepted pushes, left unreset so it maps to RAM.
        always_ff @(posedge clk) begin
            if (push_ok[gi]) begin
                mem[wr_ptr_reg] <= push_data[gi*DWID +: DWID];
            end
        end

        // Pointer and occupancy bookkeeping; simultaneous push and pop keep count steady.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop_sel[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                case ({push_ok[gi], pop_sel[gi]})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Select the head word and id of the (at most one) queue being popped.
    always_comb begin
        pop_any  = |pop_sel;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (pop_sel[i]) begin
                sel_data = head_flat[i*DWID +: DWID];
                sel_id   = CNTWID'(i);
            end
        end
    end

    // Output stream register: one-cycle valid pulse per pop, data/id hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= pop_any;
            if (pop_any) begin
                out_data <= sel_data;
                out_id   <= sel_id;
            end
        end
    end

`ifdef DWRR_GNT_CHECK_EN
    logic err_reg;
    logic gnt_violation;

    // Multi-bit grant, or any grant to a queue not currently requesting
    // (empty or blocked), is a protocol error. Pops are unaffected.
    assign gnt_violation = ((gnt & (gnt - NUM_REQS'(1))) != '0) | ((gnt & ~reqs) != '0);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (gnt_violation) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dwrr_req_queues.sv
// Directed testbench for dwrr_req_queues: a vector table of per-cycle inputs
// with hand-computed expected outputs, plus a hand-written reset sequence.
module tb_dwrr_req_queues;

    logic        clk;
    logic        rst;
    logic [3:0]  push;
    logic [31:0] push_data;
    logic [3:0]  full;
    logic        blk;
    logic [3:0]  reqs;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        err;

    int checks;
    int failures;

`ifdef DWRR_GNT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    dwrr_req_queues #(.NUM_REQS(4), .DWID(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .blk       (blk),
        .reqs      (reqs),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  push;
        logic [31:0] pdata;
        logic        blk;
        logic [3:0]  gnt;
        logic [3:0]  exp_reqs;
        logic [3:0]  exp_full;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] p, input logic [31:0] pd, input logic b,
                                input logic [3:0] g, input logic [3:0] r, input logic [3:0] f,
                                input logic v, input logic [7:0] d, input logic [1:0] id);
        vec_t t;
        t.push = p; t.pdata = pd; t.blk = b; t.gnt = g;
        t.exp_reqs = r; t.exp_full = f; t.exp_v = v; t.exp_d = d; t.exp_id = id;
        return t;
    endfunction

    function automatic logic [31:0] pd1(input int q, input logic [7:0] d);
        return {24'd0, d} << (8 * q);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        push = '0; push_data = '0; blk = 1'b0; gnt = '0;

        // Queue 2: two pushes, two grants, FIFO order and 1-cycle latency
        vecs.push_back(mk(4'b0100, pd1(2, 8'hA1), 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0100, pd1(2, 8'hA2), 0, 4'b0000, 4'b0100, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0100, 4'b0100, 4'b0000, 1, 8'hA1, 2'd2));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0100, 4'b0100, 4'b0000, 1, 8'hA2, 2'd2));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        // Queue 0: fill to DEPTH, overflow push dropped, drain in order, then empty grant
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(4'b0001, pd1(0, 8'h10 + 8'(k)), 0, 4'b0000,
                              (k == 0) ? 4'b0000 : 4'b0001, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0001, pd1(0, 8'hFF), 0, 4'b0000, 4'b0001, 4'b0001, 0, 8'h00, 2'd0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(4'b0000, 32'd0, 0, 4'b0001, 4'b0001,
                              (k == 0) ? 4'b0001 : 4'b0000, 1, 8'h10 + 8'(k), 2'd0));
        vecs.push_back(mk(4'b0000, 32'd0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        // Queue 1: push and pop together on a 1-entry queue returns the old head
        vecs.push_back(mk(4'b0010, pd1(1, 8'h33), 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0010, pd1(1, 8'h55), 0, 4'b0010, 4'b0010, 4'b0000, 1, 8'h33, 2'd1));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0010, 4'b0010, 4'b0000, 1, 8'h55, 2'd1));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        // Queues 0 and 3: blk masks reqs, multi-bit grant serves only queue 0
        vecs.push_back(mk(4'b1001, 32'h7000_0040, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0000, 32'd0,         1, 4'b1001, 4'b0000, 4'b0000, 1, 8'h40, 2'd0));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b0000, 4'b1000, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(4'b0000, 32'd0,         0, 4'b1000, 4'b1000, 4'b0000, 1, 8'h70, 2'd3));
        // Queue 1: 3*DEPTH push/pop pairs across pointer wraps
        vecs.push_back(mk(4'b0010, pd1(1, 8'h80), 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));
        for (int k = 1; k < 12; k++)
            vecs.push_back(mk(4'b0010, pd1(1, 8'h80 + 8'(k)), 0, 4'b0010, 4'b0010, 4'b0000,
                              1, 8'h80 + 8'(k - 1), 2'd1));
        vecs.push_back(mk(4'b0000, 32'd0, 0, 4'b0010, 4'b0010, 4'b0000, 1, 8'h8B, 2'd1));
        vecs.push_back(mk(4'b0000, 32'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 2'd0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset out_id",    32'(out_id),    32'd0);
        chk("reset err",       32'(err),       32'd0);
        chk("reset reqs",      32'(reqs),      32'd0);
        chk("reset full",      32'(full),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            push = vecs[i].push; push_data = vecs[i].pdata;
            blk = vecs[i].blk; gnt = vecs[i].gnt;
            #1;
            chk($sformatf("v%0d reqs", i), 32'(reqs), 32'(vecs[i].exp_reqs));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].exp_full));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_d));
                chk($sformatf("v%0d out_id", i),   32'(out_id),   32'(vecs[i].exp_id));
            end
            $display("vec %0d push=%b gnt=%b blk=%b -> reqs=%b full=%b out_valid=%b data=%h id=%0d",
                     i, vecs[i].push, vecs[i].gnt, vecs[i].blk, reqs, full, out_valid, out_data, out_id);
        end
        @(negedge clk);
        push = '0; push_data = '0; blk = 1'b0; gnt = '0;
        #1;
        chk("held out_data", 32'(out_data), 32'h8B);
        chk("err sticky", 32'(err), 32'(ERR_EXP));

        // Mid-stream reset: queues partly full and a pop in flight
        push = 4'b0101; push_data = 32'h00_C0_00_B0;
        @(negedge clk);
        push = 4'b0001; push_data = 32'h0000_00B1;
        @(negedge clk);
        push = '0; push_data = '0; gnt = 4'b0001;
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset out_data",  32'(out_data),  32'hB0);
        gnt = '0;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out_data",  32'(out_data),  32'd0);
        chk("async reset out_id",    32'(out_id),    32'd0);
        chk("async reset reqs",      32'(reqs),      32'd0);
        chk("async reset full",      32'(full),      32'd0);
        chk("async reset err",       32'(err),       32'd0);
        $display("reset asserted mid-stream -> out_valid=%b data=%h reqs=%b err=%b",
                 out_valid, out_data, reqs, err);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset reqs", 32'(reqs), 32'd0);
        @(negedge clk);
        gnt = 4'b0101;
        @(posedge clk);
        #1;
        chk("post-reset gnt out_valid", 32'(out_valid), 32'd0);
        $display("post-reset gnt=0101 -> out_valid=%b reqs=%b", out_valid, reqs);
        @(negedge clk);
        gnt = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
